// File: rtl/rx_vector_loader.sv
// ============================================================================
// Module      : rx_vector_loader
// Description : Decodes UART bytes into command strobes and vector-load
//               transactions. Each element is built from a low/high byte pair
//               and written to SIPO store A or B with a one-cycle strobe.
//               Optional macro RX_TIMEOUT_EN adds an inter-byte load timeout
//               that aborts a stalled load and pulses load_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_vector_loader #(
  parameter int DEPTH          = 1024,
  parameter int WIDTH          = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  output logic [WIDTH-1:0]         d_out,
  output logic                     wea_a,
  output logic                     wea_b,
  output logic                     cmd_strobe,
  output logic [2:0]               cmd_code,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] elem_idx,
  output logic                     load_done,
  output logic                     load_err
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD_LO = 2'd1;
  localparam logic [1:0] S_LOAD_HI = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       target_b;
  logic [7:0] lo_byte;
  logic       timeout_hit;

  logic       is_cmd;
  logic [2:0] opcode;
  logic       last_elem;

  assign is_cmd    = (rx_byte[7:4] == 4'hC);
  assign opcode    = rx_byte[3:1];
  assign last_elem = (elem_idx == IW'(DEPTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; inside a load every byte is payload, never a command
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (rx_valid && is_cmd && (opcode == 3'd1 || opcode == 3'd2))
          state_next = S_LOAD_LO;
      end
      S_LOAD_LO: begin
        if (rx_valid) state_next = S_LOAD_HI;
      end
      S_LOAD_HI: begin
        if (rx_valid) state_next = last_elem ? S_IDLE : S_LOAD_LO;
      end
      default: state_next = S_IDLE;
    endcase
    if (timeout_hit) state_next = S_IDLE;
  end

  // State-derived outputs
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Datapath: command latch, byte pairing, element write strobes, index
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out      <= '0;
      wea_a      <= 1'b0;
      wea_b      <= 1'b0;
      cmd_strobe <= 1'b0;
      cmd_code   <= 3'd0;
      elem_idx   <= '0;
      load_done  <= 1'b0;
      target_b   <= 1'b0;
      lo_byte    <= 8'd0;
    end else begin
      wea_a      <= 1'b0;
      wea_b      <= 1'b0;
      cmd_strobe <= 1'b0;
      load_done  <= 1'b0;
      if (timeout_hit) elem_idx <= '0;
      if (rx_valid) begin
        case (state)
          S_IDLE: begin
            if (is_cmd) begin
              cmd_code   <= opcode;
              cmd_strobe <= 1'b1;
              if (opcode == 3'd1) begin
                target_b <= 1'b0;
                elem_idx <= '0;
              end else if (opcode == 3'd2) begin
                target_b <= 1'b1;
                elem_idx <= '0;
              end
            end
          end
          S_LOAD_LO: lo_byte <= rx_byte;
          S_LOAD_HI: begin
            // Bits of the high byte above the element width are discarded
            d_out <= {rx_byte[WIDTH-9:0], lo_byte};
            wea_a <= ~target_b;
            wea_b <= target_b;
            if (last_elem) begin
              elem_idx  <= '0;
              load_done <= 1'b1;
            end else begin
              elem_idx  <= elem_idx + IW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;

  // Idle-cycle counter: restarts on every byte, runs only during a load
  always_ff @(posedge clk) begin
    if (rst || rx_valid || !busy) idle_cnt <= '0;
    else                          idle_cnt <= idle_cnt + TW'(1);
  end

  assign timeout_hit = busy && !rx_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Abort pulse, aligned with the return to IDLE
  always_ff @(posedge clk) begin
    if (rst) load_err <= 1'b0;
    else     load_err <= timeout_hit;
  end
`else
  // Without the timeout a stalled load waits until reset
  assign timeout_hit = 1'b0;
  assign load_err    = 1'b0;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_vector_loader.sv
// ============================================================================
// Module      : tb_rx_vector_loader
// Description : Directed self-checking bench for rx_vector_loader
//               (DEPTH=4, WIDTH=10, TIMEOUT_CYCLES=50).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_vector_loader;

  localparam int DEPTH = 4;
  localparam int WIDTH = 10;
  localparam int TMO   = 50;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       rx_byte = 8'h00;
  logic             rx_valid = 1'b0;
  logic [WIDTH-1:0] d_out;
  logic             wea_a, wea_b, cmd_strobe, busy, load_done, load_err;
  logic [2:0]       cmd_code;
  logic [1:0]       elem_idx;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int a_cnt, b_cnt, cmd_cnt, done_cnt, err_cnt, both_cnt, done_bad;
  logic [WIDTH-1:0] a_data[$];
  logic [WIDTH-1:0] b_data[$];

  rx_vector_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .d_out(d_out), .wea_a(wea_a), .wea_b(wea_b), .cmd_strobe(cmd_strobe),
    .cmd_code(cmd_code), .busy(busy), .elem_idx(elem_idx),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Observe outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (wea_a) begin a_cnt++; a_data.push_back(d_out); end
    if (wea_b) begin b_cnt++; b_data.push_back(d_out); end
    if (wea_a && wea_b) both_cnt++;
    if (cmd_strobe) cmd_cnt++;
    if (load_done) begin
      done_cnt++;
      if (!(wea_a || wea_b)) done_bad++;
    end
    if (load_err) err_cnt++;
  end

  task automatic clear_mon();
    a_cnt = 0; b_cnt = 0; cmd_cnt = 0; done_cnt = 0; err_cnt = 0;
    both_cnt = 0; done_bad = 0;
    a_data.delete(); b_data.delete();
  endtask

  // One byte followed by one idle cycle; returns on the negedge after the byte
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_byte = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({d_out, wea_a, wea_b, cmd_strobe, cmd_code, busy, elem_idx, load_done, load_err} !== '0) begin
      errors++;
      $display("FAIL %s: d_out=%h wea_a=%b wea_b=%b cmd_strobe=%b cmd_code=%0d busy=%b elem_idx=%0d load_done=%b load_err=%b, required all zero",
               tag, d_out, wea_a, wea_b, cmd_strobe, cmd_code, busy, elem_idx, load_done, load_err);
    end
  endtask

  task automatic check_queue(input string tag, input logic [WIDTH-1:0] got[$],
                             input logic [WIDTH-1:0] exp[4]);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s[%0d]: got %h required %h", tag, i,
                 (i < got.size()) ? got[i] : 'x, exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check_idle_outputs("reset_state");
  endtask

  task automatic test_load_a();
    logic [7:0]       bytes[8] = '{8'h34, 8'h12, 8'h78, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h02};
    logic [WIDTH-1:0] exp[4]   = '{10'h234, 10'h378, 10'h3FF, 10'h200};
    clear_mon();
    send_byte(8'hC2);
    checks++;
    if (cmd_strobe !== 1'b1 || cmd_code !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_a_cmd: strobe=%b code=%0d busy=%b required 1,1,1", cmd_strobe, cmd_code, busy);
    end
    @(negedge clk);
    checks++;
    if (cmd_strobe !== 1'b0) begin
      errors++;
      $display("FAIL load_a_cmd_width: cmd_strobe=%b required 0", cmd_strobe);
    end
    foreach (bytes[i]) send_byte(bytes[i]);
    idle(3);
    checks++;
    if (a_cnt !== 4 || b_cnt !== 0 || both_cnt !== 0) begin
      errors++;
      $display("FAIL load_a_strobes: a=%0d b=%0d both=%0d required 4,0,0", a_cnt, b_cnt, both_cnt);
    end
    check_queue("load_a_data", a_data, exp);
    checks++;
    if (done_cnt !== 1 || done_bad !== 0 || busy !== 1'b0 || cmd_cnt !== 1) begin
      errors++;
      $display("FAIL load_a_done: done=%0d unaligned=%0d busy=%b cmds=%0d required 1,0,0,1",
               done_cnt, done_bad, busy, cmd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]       bytes[8] = '{8'h01, 8'h00, 8'hC2, 8'h01, 8'h55, 8'h02, 8'hAA, 8'h03};
    logic [WIDTH-1:0] exp[4]   = '{10'h001, 10'h1C2, 10'h255, 10'h3AA};
    int idx_bad = 0;
    clear_mon();
    send_byte(8'hC4);
    checks++;
    if (cmd_code !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_cmd: code=%0d busy=%b required 2,1", cmd_code, busy);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (elem_idx !== 2'(i / 2)) begin
        idx_bad++;
        $display("FAIL b2b_elem_idx: byte %0d elem_idx=%0d required %0d", i, elem_idx, i / 2);
      end
      rx_byte = bytes[i];
      rx_valid = 1'b1;
    end
    @(negedge clk); rx_valid = 1'b0;
    idle(3);
    checks++;
    if (idx_bad != 0) errors++;
    checks++;
    if (b_cnt !== 4 || a_cnt !== 0 || cmd_cnt !== 1 || done_cnt !== 1 || done_bad !== 0) begin
      errors++;
      $display("FAIL b2b_strobes: b=%0d a=%0d cmds=%0d done=%0d unaligned=%0d required 4,0,1,1,0",
               b_cnt, a_cnt, cmd_cnt, done_cnt, done_bad);
    end
    check_queue("b2b_data", b_data, exp);
  endtask

  task automatic test_ignore_bytes();
    clear_mon();
    send_byte(8'h55);
    checks++;
    if (cmd_strobe !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_55: cmd_strobe=%b busy=%b required 0,0", cmd_strobe, busy);
    end
    send_byte(8'hC6);
    checks++;
    if (cmd_strobe !== 1'b1 || cmd_code !== 3'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cmd_op3: strobe=%b code=%0d busy=%b required 1,3,0", cmd_strobe, cmd_code, busy);
    end
    idle(3);
    checks++;
    if (a_cnt !== 0 || b_cnt !== 0 || cmd_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cmd_op3_quiet: a=%0d b=%0d cmds=%0d busy=%b required 0,0,1,0", a_cnt, b_cnt, cmd_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0]       bytes[8] = '{8'h9A, 8'h01, 8'hBC, 8'h02, 8'hDE, 8'h03, 8'hF0, 8'h00};
    logic [WIDTH-1:0] exp[4]   = '{10'h19A, 10'h2BC, 10'h3DE, 10'h0F0};
    send_byte(8'hC2);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h56);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_idle_outputs("mid_load_reset");
    clear_mon();
    send_byte(8'hC2);
    foreach (bytes[i]) send_byte(bytes[i]);
    idle(3);
    checks++;
    if (a_cnt !== 4 || b_cnt !== 0 || done_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reload_strobes: a=%0d b=%0d done=%0d busy=%b required 4,0,1,0", a_cnt, b_cnt, done_cnt, busy);
    end
    check_queue("reload_data", a_data, exp);
  endtask

`ifdef RX_TIMEOUT_EN
  task automatic test_stall();
    clear_mon();
    send_byte(8'hC2);
    send_byte(8'h11);
    send_byte(8'h01);
    idle(TMO + 10);
    checks++;
    if (a_cnt !== 1 || err_cnt !== 1 || done_cnt !== 0) begin
      errors++;
      $display("FAIL timeout_pulses: a=%0d err=%0d done=%0d required 1,1,0", a_cnt, err_cnt, done_cnt);
    end
    checks++;
    if (busy !== 1'b0 || elem_idx !== 2'd0) begin
      errors++;
      $display("FAIL timeout_state: busy=%b elem_idx=%0d required 0,0", busy, elem_idx);
    end
  endtask
`else
  task automatic test_stall();
    logic [7:0]       bytes[6] = '{8'h22, 8'h02, 8'h33, 8'h03, 8'h44, 8'h00};
    logic [WIDTH-1:0] exp[4]   = '{10'h111, 10'h222, 10'h333, 10'h044};
    int busy_drop = 0;
    clear_mon();
    send_byte(8'hC2);
    send_byte(8'h11);
    send_byte(8'h01);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_drop++;
    end
    checks++;
    if (busy_drop != 0 || err_cnt !== 0 || a_cnt !== 1 || elem_idx !== 2'd1) begin
      errors++;
      $display("FAIL stall_hold: busy_drops=%0d err=%0d a=%0d elem_idx=%0d required 0,0,1,1",
               busy_drop, err_cnt, a_cnt, elem_idx);
    end
    foreach (bytes[i]) send_byte(bytes[i]);
    idle(3);
    checks++;
    if (a_cnt !== 4 || done_cnt !== 1 || err_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume: a=%0d done=%0d err=%0d busy=%b required 4,1,0,0", a_cnt, done_cnt, err_cnt, busy);
    end
    check_queue("stall_data", a_data, exp);
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
    test_load_a();
    test_back_to_back();
    test_ignore_bytes();
    test_reset_mid_load();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
